// File: rtl/lif_neuron_array_pkg.sv
// ----------------------------------------------------------------------------
// lif_neuron_array_pkg
// Shared definitions for the leaky integrate-and-fire neuron array:
//   - state_e           : two-state update FSM encoding
//   - sat_max/sat_min   : saturation limits of a signed two's-complement word
//                         of a given width (valid for widths up to 31 bits)
// ----------------------------------------------------------------------------
package lif_neuron_array_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_e;

  // Largest value representable in a signed word of 'width' bits.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed word of 'width' bits.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/lif_neuron_array_sat_add_sub.sv
// ----------------------------------------------------------------------------
// sat_add_sub
// Combinational signed saturating adder/subtractor.
// Ports:
//   a_i   : signed operand A
//   b_i   : signed operand B
//   sub_i : 0 -> A + B, 1 -> A - B
//   y_o   : result clamped to [MIN, MAX] of a WIDTH-bit signed word
// ----------------------------------------------------------------------------
module sat_add_sub
  import lif_neuron_array_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    sub_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] raw;

  // One guard bit is enough: the exact sum/difference of two WIDTH-bit
  // values always fits in WIDTH+1 bits.
  assign a_ext = {a_i[WIDTH-1], a_i};
  assign b_ext = {b_i[WIDTH-1], b_i};

  always_comb begin
    raw = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    // Overflow shows up as the guard bit disagreeing with the WIDTH-bit sign;
    // the guard bit then carries the true sign of the result.
    if (raw[WIDTH] != raw[WIDTH-1]) begin
      y_o = raw[WIDTH] ? MIN_V : MAX_V;
    end else begin
      y_o = raw[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// ----------------------------------------------------------------------------
// lif_neuron_array
// Array of NEURONS leaky integrate-and-fire neurons sharing one update datapath.
// A request (index, current, threshold, leak shift, reset mode) is accepted in
// IDLE, evaluated in UPDATE, and its result is strobed one edge later.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake (ready only in IDLE, clear low)
//   in_index              : target neuron
//   in_current            : signed input current
//   threshold             : signed firing threshold
//   leak_shift            : leak = v >>> leak_shift (0 disables leak)
//   reset_mode            : 0 = reset-to-zero, 1 = reset-by-subtraction on fire
//   clear                 : synchronous zeroing of all membranes, aborts UPDATE
//   out_valid             : one-cycle result strobe
//   out_index             : neuron of the result
//   spike                 : fire flag of the result
//   membrane_out          : pre-reset membrane potential of the result
// ----------------------------------------------------------------------------
module lif_neuron_array
  import lif_neuron_array_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NEURONS = 4,
  localparam int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_index,
  input  logic signed [WIDTH-1:0] in_current,
  input  logic signed [WIDTH-1:0] threshold,
  input  logic [2:0]              leak_shift,
  input  logic                    reset_mode,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_index,
  output logic                    spike,
  output logic signed [WIDTH-1:0] membrane_out
);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [WIDTH-1:0] cur_q;
  logic signed [WIDTH-1:0] thr_q;
  logic [2:0]              shift_q;
  logic                    mode_q;

  logic signed [WIDTH-1:0] mem_q [NEURONS];

  logic                    out_valid_q;
  logic [IDX_W-1:0]        out_index_q;
  logic                    spike_q;
  logic signed [WIDTH-1:0] membrane_out_q;

  logic                    in_range;
  logic signed [WIDTH-1:0] v_sel;
  logic signed [WIDTH-1:0] leaked;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;
  logic                    fire;
  logic signed [WIDTH-1:0] wb_d;

  assign in_ready = (state_q == ST_IDLE) && !clear;

  // Update datapath, evaluated from the latched request.
  // NOTE: every always_comb output gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    in_range = (int'(idx_q) < NEURONS);
    v_sel    = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (int'(idx_q) == i) v_sel = mem_q[i];
    end
    // v - (v >>> s) shrinks |v| toward zero and never overflows.
    leaked = (shift_q == 3'd0) ? v_sel : (v_sel - (v_sel >>> shift_q));
    fire   = (sum >= thr_q);
    wb_d   = sum;
    if (fire) wb_d = mode_q ? diff : '0;
  end

  sat_add_sub #(.WIDTH(WIDTH)) u_leak_add (
    .a_i   (leaked),
    .b_i   (cur_q),
    .sub_i (1'b0),
    .y_o   (sum)
  );

  sat_add_sub #(.WIDTH(WIDTH)) u_thr_sub (
    .a_i   (sum),
    .b_i   (thr_q),
    .sub_i (1'b1),
    .y_o   (diff)
  );

  // FSM, request latches, membrane array and registered result.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      cur_q          <= '0;
      thr_q          <= '0;
      shift_q        <= '0;
      mode_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_index_q    <= '0;
      spike_q        <= 1'b0;
      membrane_out_q <= '0;
      // NOTE: the membranes are a small flop array, so they can and must be
      // reset here; a RAM macro could not be cleared in one edge.
      for (int i = 0; i < NEURONS; i++) mem_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (clear) begin
        // Clear wins over everything, including an in-flight update.
        for (int i = 0; i < NEURONS; i++) mem_q[i] <= '0;
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_valid) begin
              idx_q   <= in_index;
              cur_q   <= in_current;
              thr_q   <= threshold;
              shift_q <= leak_shift;
              mode_q  <= reset_mode;
              state_q <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            for (int i = 0; i < NEURONS; i++) begin
              if (in_range && (int'(idx_q) == i)) mem_q[i] <= wb_d;
            end
            out_valid_q    <= 1'b1;
            out_index_q    <= idx_q;
            spike_q        <= in_range && fire;
            membrane_out_q <= in_range ? sum : '0;
            state_q        <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_index    = out_index_q;
  assign spike        = spike_q;
  assign membrane_out = membrane_out_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// ----------------------------------------------------------------------------
// tb_lif_neuron_array
// Self-checking bench for lif_neuron_array (WIDTH=8, NEURONS=4): directed
// scenarios followed by random requests compared against an integer model.
// ----------------------------------------------------------------------------
module tb_lif_neuron_array;

  localparam int WIDTH   = 8;
  localparam int NEURONS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_index;
  logic signed [7:0] in_current;
  logic signed [7:0] threshold;
  logic [2:0]        leak_shift;
  logic              reset_mode;
  logic              clear;
  logic              out_valid;
  logic [1:0]        out_index;
  logic              spike;
  logic signed [7:0] membrane_out;

  int n_checks = 0;
  int n_fail   = 0;
  int model_v [NEURONS];

  lif_neuron_array #(.WIDTH(WIDTH), .NEURONS(NEURONS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_index     (in_index),
    .in_current   (in_current),
    .threshold    (threshold),
    .leak_shift   (leak_shift),
    .reset_mode   (reset_mode),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_index    (out_index),
    .spike        (spike),
    .membrane_out (membrane_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic int clamp8(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // floor(v / 2^s) for signed v
  function automatic int floor_div_pow2(input int v, input int s);
    int d;
    int q;
    d = 1 << s;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_step(input int idx, input int cur, input int thr,
                            input int sh, input int mode,
                            output int exp_spk, output int exp_mem);
    int v, leaked, sum;
    bit fire;
    v      = model_v[idx];
    leaked = (sh == 0) ? v : v - floor_div_pow2(v, sh);
    sum    = clamp8(leaked + cur);
    fire   = (sum >= thr);
    if (fire) model_v[idx] = (mode != 0) ? clamp8(sum - thr) : 0;
    else      model_v[idx] = sum;
    exp_spk = fire ? 1 : 0;
    exp_mem = sum;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NEURONS; i++) model_v[i] = 0;
  endtask

  // Drive one request, follow it to its result, and compare with the model.
  task automatic apply(input int idx, input int cur, input int thr,
                       input int sh, input int mode,
                       output int got_spk, output int got_mem);
    int es, em;
    bit ok;
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("in_ready_wait", 32'(ok), 1);
    in_valid   = 1'b1;
    in_index   = idx[1:0];
    in_current = cur[7:0];
    threshold  = thr[7:0];
    leak_shift = sh[2:0];
    reset_mode = mode[0];
    model_step(idx, cur, thr, sh, mode, es, em);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("out_valid_in_update", 32'(out_valid), 0);
    @(negedge clk);
    check("out_valid", 32'(out_valid), 1);
    check("out_index", 32'(out_index), idx);
    check("spike", 32'(spike), es);
    check("membrane_out", 32'(membrane_out), em);
    got_spk = int'(spike);
    got_mem = int'(membrane_out);
  endtask

  initial begin
    int s, m;
    int exp_q[$];
    int c_idx, c_cur, c_thr, c_sh, c_mode;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_index   = '0;
    in_current = '0;
    threshold  = '0;
    leak_shift = '0;
    reset_mode = 1'b0;
    clear      = 1'b0;
    model_clear();

    // ---- reset state ----
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_spike", 32'(spike), 0);
    check("rst_membrane_out", 32'(membrane_out), 0);
    check("rst_out_index", 32'(out_index), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);

    // ---- integrate to threshold, reset-to-zero ----
    apply(2, 4, 10, 0, 0, s, m); check("m0_mem1", m, 4);  check("m0_spk1", s, 0);
    apply(2, 4, 10, 0, 0, s, m); check("m0_mem2", m, 8);  check("m0_spk2", s, 0);
    apply(2, 4, 10, 0, 0, s, m); check("m0_mem3", m, 12); check("m0_spk3", s, 1);
    apply(2, 0, 10, 0, 0, s, m); check("m0_after", m, 0);

    // ---- same sequence, reset-by-subtraction ----
    apply(2, 4, 10, 0, 1, s, m); check("m1_mem1", m, 4);
    apply(2, 4, 10, 0, 1, s, m); check("m1_mem2", m, 8);
    apply(2, 4, 10, 0, 1, s, m); check("m1_mem3", m, 12); check("m1_spk3", s, 1);
    apply(2, 0, 10, 0, 1, s, m); check("m1_after", m, 2);

    // ---- saturation ----
    apply(1, 100, 127, 0, 0, s, m); check("satp_mem1", m, 100); check("satp_spk1", s, 0);
    apply(1, 100, 127, 0, 0, s, m); check("satp_mem2", m, 127); check("satp_spk2", s, 1);
    apply(3, -100, 10, 0, 0, s, m); check("satn_mem1", m, -100); check("satn_spk1", s, 0);
    apply(3, -100, 10, 0, 0, s, m); check("satn_mem2", m, -128); check("satn_spk2", s, 0);

    // ---- leak ----
    apply(0, 64, 127, 0, 0, s, m);  check("leak_set64", m, 64);
    apply(0, 0, 127, 1, 0, s, m);   check("leak_64", m, 32);
    apply(0, -35, 127, 0, 0, s, m); check("leak_setm3", m, -3);
    apply(0, 0, 127, 1, 0, s, m);   check("leak_m3", m, -1);

    // ---- clear during UPDATE aborts and zeroes all membranes ----
    @(negedge clk);
    in_valid = 1'b1; in_index = 2'd1; in_current = 8'sd50;
    threshold = 8'sd127; leak_shift = 3'd0; reset_mode = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_clear();
    @(negedge clk); check("clr_no_valid1", 32'(out_valid), 0);
    @(negedge clk); check("clr_no_valid2", 32'(out_valid), 0);
    for (int n = 0; n < NEURONS; n++) begin
      apply(n, 0, 127, 0, 0, s, m);
      check("clr_readback", m, 0);
    end

    // ---- in_valid held high: accept every other cycle ----
    apply(1, 20, 127, 0, 0, s, m);
    @(negedge clk);
    in_valid = 1'b1; in_index = 2'd1; in_current = 8'sd3;
    threshold = 8'sd127; leak_shift = 3'd0; reset_mode = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check("bb_in_ready", 32'(in_ready), ((k % 2) == 0) ? 1 : 0);
      if (k >= 2) begin
        check("bb_out_valid", 32'(out_valid), ((k % 2) == 0) ? 1 : 0);
        if ((k % 2) == 0 && exp_q.size() > 0) begin
          check("bb_membrane", 32'(membrane_out), exp_q.pop_front());
        end
      end
      if ((k % 2) == 0 && in_valid) begin
        model_step(1, 3, 127, 0, 0, s, m);
        exp_q.push_back(m);
      end
      if (k == 9) in_valid = 1'b0;
      @(negedge clk);
    end
    check("bb_queue_drained", exp_q.size(), 0);

    // ---- reset asserted mid-UPDATE drops the update ----
    apply(3, 40, 127, 0, 0, s, m);
    @(negedge clk);
    in_valid = 1'b1; in_index = 2'd3; in_current = 8'sd5;
    threshold = 8'sd127; leak_shift = 3'd0; reset_mode = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 reset = 1'b1;
    model_clear();
    @(negedge clk); check("rstu_no_valid1", 32'(out_valid), 0);
    reset = 1'b0;
    @(negedge clk); check("rstu_no_valid2", 32'(out_valid), 0);
    for (int n = 0; n < NEURONS; n++) begin
      apply(n, 0, 127, 0, 0, s, m);
      check("rstu_readback", m, 0);
    end

    // ---- random requests against the model ----
    for (int r = 0; r < 60; r++) begin
      c_idx  = int'($urandom_range(0, NEURONS - 1));
      c_cur  = int'($urandom_range(0, 255)) - 128;
      c_thr  = int'($urandom_range(0, 255)) - 128;
      c_sh   = int'($urandom_range(0, 7));
      c_mode = int'($urandom_range(0, 1));
      apply(c_idx, c_cur, c_thr, c_sh, c_mode, s, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
